sub_share_arbiter: RTL and testbench
====================================

// Module: sub_share_arbiter
// PURPOSE
//   Shares one WIDTH-bit subtractor (a - b) between NREQ requesters.
//   Round-robin arbitration, valid/ready handshake on each request port and on the single result port.
//   Each result is tagged with the requester index, the WIDTH-bit difference and a borrow flag.
//   A saturating borrow counter is kept for status readout on the top-level pins.
// PARAMETERS
//   WIDTH  8  operand/result width in bits
//   NREQ   2  number of requesters (2..4); IDW = $clog2(NREQ)
// PORTS
//   clk         in   1           clock, rising edge
//   rst_n       in   1           asynchronous active-low reset
//   ena         in   1           1 = new grants allowed; 0 = finish in-flight op, grant nothing new
//   req_valid   in   NREQ        request i presents operands
//   req_a       in   NREQ*WIDTH  minuend of request i, bits [i*WIDTH +: WIDTH]
//   req_b       in   NREQ*WIDTH  subtrahend of request i, same packing
//   req_ready   out  NREQ        one-hot accept strobe, one cycle
//   res_valid   out  1           result available
//   res_ready   in   1           consumer accepts result
//   res_data    out  WIDTH       (a - b) mod 2^WIDTH
//   res_borrow  out  1           1 when a < b (unsigned)
//   res_id      out  IDW         index of the requester that produced the result
//   busy        out  1           1 whenever state != IDLE
//   cnt_clr     in   1           synchronous clear of borrow_cnt
//   borrow_cnt  out  8           saturating count of borrow results delivered
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, all outputs 0 (res_*, req_ready, busy, borrow_cnt).
//     Reset mid-operation discards the latched operands and any pending result; no res_valid after release.
//   FSM states: IDLE -> EXEC -> DONE -> IDLE.
//   IDLE: if ena && |req_valid, grant the first valid index at or after rr_ptr (wrapping NREQ-1 -> 0).
//     - req_ready[g] is asserted combinationally in this cycle only (depends on state, ena, req_valid, rr_ptr).
//     - Latch a_g, b_g and id=g; go to EXEC.
//     - rr_ptr <= (g+1) mod NREQ.
//     No valid requests or ena=0: stay in IDLE, req_ready=0.
//   EXEC: register res_data = a - b (WIDTH bits, carry-out dropped), res_borrow = (a < b), res_id = id.
//     Go to DONE.
//   DONE: res_valid=1, and res_data/res_borrow/res_id are held stable.
//     - res_ready=1: accept; go to IDLE next cycle, res_valid deasserts.
//     - res_ready=0: hold indefinitely; no grants while in DONE.
//   Latency: accept at cycle N -> res_valid at cycle N+2. Best-case throughput is one op per 3 cycles.
//   Requesters may drop req_valid before they are granted, with no effect.
//     Operands are sampled only in the grant cycle; later changes are ignored.
//   borrow_cnt increments on a DONE handshake (res_valid & res_ready) when res_borrow=1.
//     Saturates at 0xFF (no wrap).
//     cnt_clr has priority: clr together with a counted handshake leaves 0.
//   ena falling during EXEC/DONE does not abort the operation; the result is still delivered.
//   NREQ is not a power of two: the pointer wraps at NREQ-1; indices >= NREQ are never granted.
// TESTING
//   1. req0 a=0x05 b=0x03 -> req_ready=01 at N; res_valid at N+2, data=0x02, borrow=0, id=0.
//   2. req1 a=0x03 b=0x05 -> data=0xFE, borrow=1, id=1; after handshake borrow_cnt=1.
//   3. Both requests held valid, res_ready=1 -> grant order 0,1,0,1; each grant 3 cycles apart.
//   4. res_ready=0 for 5 cycles in DONE -> res_* stable, req_ready=0 throughout, busy=1.
//   5. 300 borrow results -> borrow_cnt=0xFF. Then cnt_clr together with a borrow handshake -> 0x00.
//   6. rst_n low during EXEC, then released -> all outputs 0, rr_ptr=0, no res_valid; the next grant goes to req0.

Source files
------------

// File: rtl/sub_share_arbiter.sv
// sub_share_arbiter
//   Shares one WIDTH-bit subtractor (a - b) between NREQ requesters with
//   round-robin arbitration. Each result carries the requester index, the
//   difference and a borrow flag. A saturating count of delivered borrow
//   results is exposed for status readout.
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   ena                allow new grants (in-flight op always completes)
//   req_valid/a/b      per-requester operands, packed [i*WIDTH +: WIDTH]
//   req_ready          one-hot, single-cycle accept strobe
//   res_valid/ready    result handshake
//   res_data           (a - b) mod 2^WIDTH
//   res_borrow         a < b (unsigned)
//   res_id             index of the requester that produced the result
//   busy               FSM not idle
//   cnt_clr            synchronous clear of borrow_cnt (wins over increment)
//   borrow_cnt         saturating borrow-result count
module sub_share_arbiter #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREQ  = 2,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic                  res_borrow,
  output logic [IDW-1:0]        res_id,
  output logic                  busy,
  input  logic                  cnt_clr,
  output logic [7:0]            borrow_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   rr_next;
  logic             grant_found;
  logic             grant_go;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDW-1:0]   id_q;
  logic             res_hs;

  // First valid requester at or after rr_ptr, wrapping at NREQ-1 so that
  // indices >= NREQ are never produced for non-power-of-two NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_found && req_valid[(32'(rr_ptr) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((32'(rr_ptr) + k) % NREQ);
      end
    end
  end

  // Gated by rst_n so req_ready reads 0 while reset is held, even if the
  // requesters keep valid asserted.
  assign grant_go = rst_n && (state == IDLE) && ena && grant_found;
  assign rr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (grant_go) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_go) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      res_data   <= '0;
      res_borrow <= 1'b0;
      res_id     <= '0;
    end else begin
      if (grant_go) begin
        a_q    <= req_a[grant_idx*WIDTH +: WIDTH];
        b_q    <= req_b[grant_idx*WIDTH +: WIDTH];
        id_q   <= grant_idx;
        rr_ptr <= rr_next;
      end
      if (state == EXEC) begin
        res_data   <= a_q - b_q;
        res_borrow <= (a_q < b_q);
        res_id     <= id_q;
      end
    end
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_hs    = res_valid && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      borrow_cnt <= '0;
    else if (cnt_clr)                                borrow_cnt <= '0;
    else if (res_hs && res_borrow && borrow_cnt != '1) borrow_cnt <= borrow_cnt + 8'd1;
  end

endmodule

// File: tb/tb_sub_share_arbiter.sv
module tb_sub_share_arbiter;

  localparam int W = 8;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n, ena, res_ready, cnt_clr;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           res_valid, res_borrow, busy;
  logic [W-1:0]   res_data;
  logic [0:0]     res_id;
  logic [7:0]     borrow_cnt;

  sub_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_borrow(res_borrow), .res_id(res_id), .busy(busy),
    .cnt_clr(cnt_clr), .borrow_cnt(borrow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       b;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   m_state  = 0;   // 0 idle, 1 exec, 2 done
  int   m_rr     = 0;
  int   m_cnt    = 0;
  int   cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_res_valid"},  32'(res_valid),  0);
    check({tag, "_res_data"},   32'(res_data),   0);
    check({tag, "_res_borrow"}, 32'(res_borrow), 0);
    check({tag, "_res_id"},     32'(res_id),     0);
    check({tag, "_req_ready"},  32'(req_ready),  0);
    check({tag, "_busy"},       32'(busy),       0);
    check({tag, "_borrow_cnt"}, 32'(borrow_cnt), 0);
  endtask

  // Called just after a negedge once inputs for the cycle are set: checks
  // the cycle's outputs against the model, then advances the model across
  // the coming posedge and returns at the next negedge.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    int           g;
    logic         hs_borrow;
    exp_t         e;
    #1;
    check("busy",       32'(busy),       32'(m_state != 0));
    check("res_valid",  32'(res_valid),  32'(m_state == 2));
    check("borrow_cnt", 32'(borrow_cnt), 32'(m_cnt));
    exp_rdy = '0;
    g = -1;
    if (m_state == 0 && ena) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    hs_borrow = 1'b0;
    if (m_state == 2) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(res_valid), 0);
      end else begin
        e = sb[0];
        check("res_data",   32'(res_data),   32'(e.d));
        check("res_borrow", 32'(res_borrow), 32'(e.b));
        check("res_id",     32'(res_id),     32'(e.id));
        if (res_ready) begin
          hs_borrow = e.b;
          void'(sb.pop_front());
        end
      end
    end
    if (cnt_clr) m_cnt = 0;
    else if (m_state == 2 && res_ready && hs_borrow && m_cnt != 255) m_cnt++;
    case (m_state)
      0: if (g >= 0) begin
           e.id = g;
           e.d  = req_a[g*W +: W] - req_b[g*W +: W];
           e.b  = req_a[g*W +: W] < req_b[g*W +: W];
           sb.push_back(e);
           m_rr = (g + 1) % N;
           m_state = 1;
           grant_log.push_back(g);
           grant_cyc.push_back(cyc);
         end
      1: m_state = 2;
      default: if (res_ready) m_state = 0;
    endcase
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; res_ready = 1'b0; cnt_clr = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0;
    #3;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: req0 5-3, operands changed after grant must be ignored
    ena = 1'b1; res_ready = 1'b1;
    req_valid = 2'b01; req_a = {8'h00, 8'h05}; req_b = {8'h00, 8'h03};
    tick();
    req_valid = '0; req_a[7:0] = 8'hAA; req_b[7:0] = 8'h11;
    tick(); tick(); tick();

    // 2: req1 3-5 -> borrow
    req_valid = 2'b10; req_a = {8'h03, 8'h00}; req_b = {8'h05, 8'h00};
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    check("t2_borrow_cnt", 32'(borrow_cnt), 1);

    // 3: both valid, alternating grants 3 cycles apart
    grant_log.delete(); grant_cyc.delete();
    req_valid = 2'b11; req_a = {8'h80, 8'h10}; req_b = {8'h7F, 8'h20};
    repeat (12) tick();
    req_valid = '0;
    check("t3_ngrants", 32'(grant_log.size()), 4);
    for (int k = 0; k < grant_log.size(); k++)
      check("t3_order", 32'(grant_log[k]), 32'(k % 2));
    for (int k = 0; k + 1 < grant_cyc.size(); k++)
      check("t3_gap", 32'(grant_cyc[k+1] - grant_cyc[k]), 3);
    tick();

    // 4: stall in DONE for 5 cycles with requests pending
    res_ready = 1'b0; req_valid = 2'b01;
    req_a = {8'h44, 8'h9C}; req_b = {8'h22, 8'hA0};
    tick();
    req_valid = 2'b11;
    tick();
    repeat (5) tick();
    res_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();

    // ena low: no grants; ena falling in EXEC still delivers
    ena = 1'b0; req_valid = 2'b11;
    repeat (3) tick();
    ena = 1'b1;
    tick();
    ena = 1'b0;
    tick(); tick();
    req_valid = '0; ena = 1'b1;
    tick();

    // 5: 300 borrow results saturate the counter, then clear wins
    req_valid = 2'b10; req_a = {8'h03, 8'h00}; req_b = {8'h05, 8'h00};
    repeat (900) tick();
    check("t5_sat", 32'(borrow_cnt), 32'h0FF);
    tick(); tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; req_valid = '0;
    #1 check("t5_clr", 32'(borrow_cnt), 0);
    tick();

    // 6: reset during EXEC with rr_ptr pointing at req1
    req_valid = 2'b11; req_a = {8'h09, 8'h07}; req_b = {8'h01, 8'h08};
    tick();
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_rst");
    m_state = 0; m_rr = 0; m_cnt = 0; sb.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 check("t6_grant_req0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick(); tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
